// File: rtl/rect_fill_sequencer_if.sv
// Requester and framebuffer-write bundle for rect_fill_sequencer.
// The slave side is the sequencer. The master side drives requests and wr_ready.
interface rect_fill_sequencer_if #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ*ADDR_W-1:0]  req_startaddr;
  logic [NREQ*10-1:0]      req_w;
  logic [NREQ*10-1:0]      req_h;
  logic [NREQ*COLOR_W-1:0] req_color;
  logic [NREQ-1:0]         grant;

  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [COLOR_W-1:0]      wr_data;
  logic                    wr_ready;

  logic                    busy;
  logic                    done;
  logic [1:0]              done_id;

  modport master (
    output req, req_startaddr, req_w, req_h, req_color, wr_ready,
    input  grant, wr_en, wr_addr, wr_data, busy, done, done_id
  );

  modport slave (
    input  req, req_startaddr, req_w, req_h, req_color, wr_ready,
    output grant, wr_en, wr_addr, wr_data, busy, done, done_id
  );
endinterface

// File: rtl/rect_fill_sequencer.sv
// Round-robin rectangle fill sequencer for the 640x480 lightbike framebuffer.
// It walks the granted rectangle row-major and issues one write per on-screen pixel.
module rect_fill_sequencer #(
  parameter int NREQ     = 2,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 8
) (
  input logic                 clk,
  input logic                 rst,
  rect_fill_sequencer_if.slave bus
);

  localparam logic [19:0] PIX_LIMIT  = 20'(SCREEN_W * SCREEN_H);
  localparam logic [19:0] ROW_STRIDE = 20'(SCREEN_W);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t             state;
  logic [1:0]         rr_ptr;
  logic [1:0]         cap_id;
  logic [9:0]         cap_w;
  logic [9:0]         cap_h;
  logic [COLOR_W-1:0] cap_color;
  logic [9:0]         col;
  logic [9:0]         row;
  logic [19:0]        row_base;
  logic [19:0]        pix;
  logic [NREQ-1:0]    grant_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         done_id_q;

  logic               found;
  logic [1:0]         win;
  logic [1:0]         next_ptr;
  logic [ADDR_W-1:0]  win_start;
  logic [9:0]         win_w;
  logic [9:0]         win_h;
  logic [COLOR_W-1:0] win_color;
  logic               pix_on;
  logic               advance;
  logic               last_col;
  logic               last_row;

  // Round-robin search: requesters at or above rr_ptr first, then the wrapped-around ones.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_start = '0;
    win_w     = '0;
    win_h     = '0;
    win_color = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i] && (i >= int'(rr_ptr))) begin
        found     = 1'b1;
        win       = 2'(i);
        win_start = bus.req_startaddr[i*ADDR_W +: ADDR_W];
        win_w     = bus.req_w[i*10 +: 10];
        win_h     = bus.req_h[i*10 +: 10];
        win_color = bus.req_color[i*COLOR_W +: COLOR_W];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i] && (i < int'(rr_ptr))) begin
        found     = 1'b1;
        win       = 2'(i);
        win_start = bus.req_startaddr[i*ADDR_W +: ADDR_W];
        win_w     = bus.req_w[i*10 +: 10];
        win_h     = bus.req_h[i*10 +: 10];
        win_color = bus.req_color[i*COLOR_W +: COLOR_W];
      end
    end
    next_ptr = (int'(win) == NREQ - 1) ? 2'd0 : win + 2'd1;
  end

  // Off-screen pixels never wait for wr_ready; they are skipped at one per cycle.
  assign pix_on   = (state == FILL) && (pix < PIX_LIMIT);
  assign advance  = !pix_on || bus.wr_ready;
  assign last_col = (col == cap_w - 10'd1);
  assign last_row = (row == cap_h - 10'd1);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cap_id    <= '0;
      cap_w     <= '0;
      cap_h     <= '0;
      cap_color <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      pix       <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_q   <= NREQ'(1) << win;
            rr_ptr    <= next_ptr;
            cap_id    <= win;
            cap_w     <= win_w;
            cap_h     <= win_h;
            cap_color <= win_color;
            col       <= '0;
            row       <= '0;
            row_base  <= 20'(win_start);
            pix       <= 20'(win_start);
            busy_q    <= 1'b1;
            state     <= (win_w == 10'd0 || win_h == 10'd0) ? DONE : FILL;
          end
        end
        FILL: begin
          if (advance) begin
            if (last_col) begin
              col      <= '0;
              row      <= row + 10'd1;
              row_base <= row_base + ROW_STRIDE;
              pix      <= row_base + ROW_STRIDE;
              if (last_row) begin
                state     <= DONE;
                done_q    <= 1'b1;
                done_id_q <= cap_id;
              end
            end else begin
              col <= col + 10'd1;
              pix <= pix + 20'd1;
            end
          end
        end
        DONE: begin
          // A zero-size job arrives here without done raised; it spends one extra cycle to pulse it.
          if (done_q) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            done_q    <= 1'b1;
            done_id_q <= cap_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.wr_en   = pix_on;
  assign bus.wr_addr = pix[ADDR_W-1:0];
  assign bus.wr_data = cap_color;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_rect_fill_sequencer.sv
// Self-checking bench for rect_fill_sequencer: directed scenarios plus randomized jobs,
// each compared against a pixel-list and cycle-count model of the fill rules.
module tb_rect_fill_sequencer;

  localparam int NREQ      = 2;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int ADDR_W    = 19;
  localparam int COLOR_W   = 8;
  localparam int PIX_LIMIT = SCREEN_W * SCREEN_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rect_fill_sequencer_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

  rect_fill_sequencer #(
    .NREQ(NREQ), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NREQ-1:0]    req_v = '0;
  logic               rdy   = 1'b1;
  logic [ADDR_W-1:0]  p_start [NREQ];
  logic [9:0]         p_w     [NREQ];
  logic [9:0]         p_h     [NREQ];
  logic [COLOR_W-1:0] p_color [NREQ];

  assign bus.req      = req_v;
  assign bus.wr_ready = rdy;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign bus.req_startaddr[gi*ADDR_W +: ADDR_W]  = p_start[gi];
    assign bus.req_w[gi*10 +: 10]                  = p_w[gi];
    assign bus.req_h[gi*10 +: 10]                  = p_h[gi];
    assign bus.req_color[gi*COLOR_W +: COLOR_W]    = p_color[gi];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int rr_ptr_m = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] r, int ptr);
    for (int i = 0; i < NREQ; i++) begin
      int idx = (ptr + i) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int id, input int start, input int w, input int h, input int color);
    p_start[id] = ADDR_W'(start);
    p_w[id]     = 10'(w);
    p_h[id]     = 10'(h);
    p_color[id] = COLOR_W'(color);
  endtask

  // Waits for a grant to exp_id, then follows the job to done, checking every write
  // against the expected pixel list and the done cycle against the expected latency.
  // mode: 0 = wr_ready high, 1 = random wr_ready, 2 = stall the first write 3 cycles.
  task automatic expect_job(input int exp_id, input int mode, input bit keep,
                            output int g_cyc, output int d_cyc, output int stalls);
    int q[$];
    int s, w, h, pix, tot, exp_dt, stall_left, lim;
    logic [COLOR_W-1:0] color_e;
    logic [NREQ-1:0] grant_e;
    bit got_done, extra_grant;
    g_cyc = -1; d_cyc = -1; stalls = 0;
    for (lim = 0; lim < 20 && bus.grant == '0; lim++) tick();
    grant_e = '0;
    grant_e[exp_id] = 1'b1;
    checks++;
    if (bus.grant !== grant_e) begin
      failures++;
      $display("FAIL grant: got %b expected %b at cycle %0d", bus.grant, grant_e, cyc);
      return;
    end
    g_cyc = cyc;
    s = int'(p_start[exp_id]); w = int'(p_w[exp_id]); h = int'(p_h[exp_id]);
    color_e = p_color[exp_id];
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        pix = (s + r * SCREEN_W + c) % (1 << 20);
        if (pix < PIX_LIMIT) q.push_back(pix);
      end
    tot = w * h;
    rr_ptr_m = (exp_id + 1) % NREQ;
    if (!keep) begin
      // The job must run from the values captured at the grant edge.
      req_v[exp_id] = 1'b0;
      set_req(exp_id, int'($urandom_range(0, 400000)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
    end
    stall_left  = (mode == 2) ? 3 : 0;
    got_done    = 1'b0;
    extra_grant = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      case (mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = (stall_left == 0);
        default: rdy = 1'b1;
      endcase
      if (bus.done) begin got_done = 1'b1; break; end
      if (k > 0 && bus.grant != '0) extra_grant = 1'b1;
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_job: got %b expected 1 at cycle %0d", bus.busy, cyc);
      end
      if (bus.wr_en) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL extra_write: got addr %0d, expected no write", bus.wr_addr);
        end else if (int'(bus.wr_addr) != q[0] || bus.wr_data !== color_e) begin
          failures++;
          $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                   bus.wr_addr, bus.wr_data, q[0], color_e);
          if (rdy) void'(q.pop_front());
        end else if (rdy) begin
          void'(q.pop_front());
        end
        if (!rdy) begin
          stalls++;
          if (stall_left > 0) stall_left--;
        end
      end
      tick();
    end
    rdy = 1'b1;
    checks++;
    if (!got_done) begin
      failures++;
      $display("FAIL done_timeout: no done for requester %0d", exp_id);
      return;
    end
    d_cyc  = cyc;
    exp_dt = (tot == 0) ? 1 : tot + stalls;
    if (int'(bus.done_id) != exp_id) begin
      failures++;
      $display("FAIL done_id: got %0d expected %0d", bus.done_id, exp_id);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: got %0d writes short, expected 0", q.size());
    end
    checks++;
    if (d_cyc - g_cyc != exp_dt) begin
      failures++;
      $display("FAIL done_latency: got %0d cycles expected %0d", d_cyc - g_cyc, exp_dt);
    end
    checks++;
    if (extra_grant) begin
      failures++;
      $display("FAIL grant_pulse: got grant beyond one cycle, expected one-cycle pulse");
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (bus.grant !== '0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got grant=%b wr_en=%b busy=%b done=%b expected all 0",
               bus.grant, bus.wr_en, bus.busy, bus.done);
    end
    checks++;
    if (bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.done_id !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%0h data=%0h id=%0d expected 0",
               bus.wr_addr, bus.wr_data, bus.done_id);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== '0) begin
      failures++;
      $display("FAIL idle_no_req: got busy=%b grant=%b expected 0", bus.busy, bus.grant);
    end
  endtask

  task automatic test_contention();
    int want [4] = '{0, 1, 0, 1};
    int g, d, st, prev_d;
    set_req(0, 100, 2, 2, 'h33);
    set_req(1, 50000, 3, 1, 'hC4);
    req_v  = 2'b11;
    prev_d = -1;
    for (int k = 0; k < 4; k++) begin
      expect_job(want[k], 0, 1'b1, g, d, st);
      if (k == 3) req_v = '0;
      if (prev_d >= 0) begin
        checks++;
        if (g != prev_d + 2) begin
          failures++;
          $display("FAIL regrant_gap: got grant at %0d expected %0d", g, prev_d + 2);
        end
      end
      prev_d = d;
    end
  endtask

  task automatic test_single();
    int g, d, st;
    set_req(0, 645, 3, 2, 'h1C);
    req_v = 2'b01;
    expect_job(0, 0, 1'b0, g, d, st);
  endtask

  task automatic test_backpressure();
    int g, d, st;
    set_req(0, 9000, 2, 1, 'hA5);
    req_v = 2'b01;
    expect_job(0, 2, 1'b0, g, d, st);
    checks++;
    if (st != 3 || d - g != 5) begin
      failures++;
      $display("FAIL backpressure: got stalls=%0d latency=%0d expected 3 and 5", st, d - g);
    end
  endtask

  task automatic test_bottom_clip();
    int g, d, st;
    set_req(1, 306560, 2, 2, 'h7E);
    req_v = 2'b10;
    expect_job(rr_pick(req_v, rr_ptr_m), 0, 1'b0, g, d, st);
  endtask

  task automatic test_zero_size();
    int g, d, st;
    set_req(0, 1234, 0, 5, 'h11);
    req_v = 2'b01;
    expect_job(0, 0, 1'b0, g, d, st);
  endtask

  task automatic test_reset_mid_fill();
    int g, d, st, cnt, lim;
    set_req(0, 1000, 10, 10, 'h55);
    req_v = 2'b01;
    for (lim = 0; lim < 20 && bus.grant == '0; lim++) tick();
    checks++;
    if (bus.grant !== 2'b01) begin
      failures++;
      $display("FAIL mid_grant: got %b expected 01", bus.grant);
    end
    req_v = '0;
    cnt = 0;
    for (int k = 0; k < 300 && cnt < 37; k++) begin
      if (bus.wr_en) cnt++;
      if (cnt < 37) tick();
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== '0 || bus.done !== 1'b0 ||
        bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      failures++;
      $display("FAIL async_reset: got wr_en=%b busy=%b grant=%b done=%b addr=%0h data=%0h expected 0",
               bus.wr_en, bus.busy, bus.grant, bus.done, bus.wr_addr, bus.wr_data);
    end
    rr_ptr_m = 0;
    set_req(1, 2000, 2, 2, 'h9B);
    req_v = 2'b10;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.grant !== '0) begin
        failures++;
        $display("FAIL in_reset: got done=%b grant=%b expected 0", bus.done, bus.grant);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    expect_job(1, 0, 1'b0, g, d, st);
  endtask

  task automatic test_random();
    int g, d, st, region, start;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        region = int'($urandom_range(0, 2));
        case (region)
          0:       start = int'($urandom_range(0, 2000));
          1:       start = int'($urandom_range(305000, 307199));
          default: start = int'($urandom_range(307200, 310000));
        endcase
        set_req(i, start, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 255)));
      end
      req_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      expect_job(rr_pick(req_v, rr_ptr_m), 1, 1'b0, g, d, st);
    end
    req_v = '0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0);
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_bottom_clip();
    test_zero_size();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rect_fill_sequencer.md
# rect_fill_sequencer

Sequences rectangle fills into the 640×480 framebuffer for the lightbike game. Arbitrates round-robin among several requesters (player trails, arena walls, clear-screen), each supplying a start address, width, height and color. Walks the granted rectangle row-major and emits one framebuffer write per pixel through a valid/ready write port. It is the write-side counterpart of the combinational rectangle-membership checks used on the VGA read path.

## Interface
- NREQ, 2, number of requesters (2..4)
- SCREEN_W, 640, pixels per row / row stride in addresses
- SCREEN_H, 480, rows on screen
- ADDR_W, 19, framebuffer address width
- COLOR_W, 8, pixel data width

- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NREQ  per-requester request level; held until grant
- req_startaddr  in  NREQ*ADDR_W  packed top-left address, requester i at bits [i*ADDR_W +: ADDR_W]
- req_w  in  NREQ*10  packed width in pixels
- req_h  in  NREQ*10  packed height in rows
- req_color  in  NREQ*COLOR_W  packed fill color
- grant  out  NREQ  one-hot, one-cycle pulse; request parameters captured at that edge
- wr_en  out  1  framebuffer write valid
- wr_addr  out  ADDR_W  write address
- wr_data  out  COLOR_W  write data (captured color)
- wr_ready  in  1  framebuffer accepts write when wr_en & wr_ready
- busy  out  1  high in FILL and DONE
- done  out  1  one-cycle pulse after last pixel of a job
- done_id  out  2  index of the requester whose job finished, valid with done

## Operation
- States: IDLE, FILL, DONE.
- IDLE: if any req bit is set, pick the winner round-robin, searching from rr_ptr upward with wrap. On the edge: capture start/w/h/color/id; pulse grant[winner]; set rr_ptr = winner+1 mod NREQ. Go to FILL, or to DONE if w==0 or h==0 (no writes).
- FILL: col and row are 10-bit counters, and row_base is a 20-bit register starting at startaddr.
- Pixel address: pix = row_base + col, 20-bit.
- wr_en is high when pix < SCREEN_W*SCREEN_H; wr_addr = pix[ADDR_W-1:0].
- Off-screen pixels (pix ≥ 307200) are skipped: wr_en stays low and the counters advance one per cycle without waiting for wr_ready.
- Advance occurs when the write is accepted (wr_en & wr_ready) or the pixel is skipped:
  - If col == w-1: col=0, row_base += SCREEN_W, row++.
  - Otherwise: col++.
- After the pixel at row == h-1, col == w-1 advances, go to DONE.
- While wr_en is high and wr_ready is low, wr_addr and wr_data are held stable and the counters are frozen.
- DONE: done=1 and done_id=captured id for exactly one cycle, then IDLE. No arbitration occurs in DONE.
- Requests arriving during FILL/DONE wait. A req dropped before grant is simply not served.
- Horizontal overflow is not clipped: a rectangle running past the right edge wraps into the next row, matching the linear-address semantics of the read-side checks.

## Timing
- Reset: state=IDLE, grant=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, done_id=0, rr_ptr=0, counters=0.
- Reset asserted mid-FILL aborts the job immediately: wr_en drops asynchronously and no done is issued.
- Grant edge E: grant is high in cycle E+1. The first wr_en (first pixel on-screen) is also in cycle E+1.
- With wr_ready tied high and all pixels on-screen:
  - writes occur in cycles E+1 .. E+w*h;
  - done is high in cycle E+w*h+1;
  - the next grant edge is no earlier than the end of cycle E+w*h+2.
- Zero-size job: grant in E+1 with busy high, done in E+2, no wr_en.
- Output registration:
  - wr_en, wr_addr, wr_data, grant, done and busy are all driven from registers.
  - wr_en may be decoded from registered state plus registered pix.
  - No output depends combinationally on req or wr_ready.
- Simultaneous events:
  - req asserted in the DONE cycle is sampled in the following IDLE cycle.
  - If the granted requester deasserts req after grant, the job completes unaffected.

## Test plan
- Single job, requester 0: start=645, w=3, h=2, color=0x1C, wr_ready=1 -> grant[0] one cycle; writes 645,646,647,1285,1286,1287 on consecutive cycles, all data 0x1C; done with done_id=0 on the next cycle; busy low after.
- Contention: req=2'b11 from IDLE -> grant[0] first. When req stays 2'b11 after done, the next grant is grant[1], then grant[0]: strict alternation over 4 jobs.
- Backpressure: w=2, h=1, wr_ready low for 3 cycles on the first write -> wr_addr/wr_data held stable 4 cycles; exactly 2 accepted writes; done arrives 3 cycles later than without stall.
- Bottom clip: start=306560 (row 479, col 0), w=2, h=2 -> writes only 306560 and 306561; the 2 off-screen pixels are skipped with wr_en low for 2 cycles; done follows.
- Zero size: w=0, h=5 -> grant, then done next cycle, no wr_en ever.
- Reset during FILL of a 10×10 job after 37 writes -> all outputs 0 immediately, no done. After release with req[1] high, grant[1] comes first (rr_ptr=0 search finds 1 if req[0] low).
